truth_table_sweep: RTL and testbench

Stimulus/capture stage wrapped around one 3-input combinational logic module (the 3-input-case truth-table family). Drives in1..in3 through all eight codes 000..111, waits a programmable settle time per code, samples the module's `out` twice, and assembles the measured 8-bit truth-table word in the same hex encoding used to name those modules. It also flags any code whose output is unstable. It sits directly upstream (input drive) and downstream (output capture) of the device under test.

---
 rtl/truth_table_sweep.sv | 191 +++++++++++++++++++
 tb/tb_truth_table_sweep.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweep.sv
// truth_table_sweep
//
// Stimulus/capture stage for a 3-input combinational logic module. Walks the
// module inputs through codes 000..111, holds each code for Settle cycles,
// samples the module output on two consecutive cycles and assembles the
// measured 8-bit truth-table word (bit i = output for code i, code 000 -> bit 0).
// Codes whose two samples disagree are flagged in unstable_o.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset (synchronous release expected)
//   start_i      sweep request, accepted only while busy_o = 0
//   abort_i      synchronous cancel of a running sweep
//   dut_out_i    output of the logic module under test
//   in1_o..in3_o drive to the module, {in1_o, in2_o, in3_o} = current code
//   busy_o       sweep in progress
//   done_o       one-cycle pulse; table_out_o/unstable_o updated in this cycle
//   table_out_o  measured truth table of the last completed sweep
//   unstable_o   per-code flag: the two samples differed
//
// All outputs are decoded from registers only; dut_out_i and start_i never
// reach an output combinationally.

module truth_table_sweep #(
  // Cycles each code is held before the first sample; legal range 1..255.
  parameter int unsigned Settle = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       dut_out_i,
  output logic       in1_o,
  output logic       in2_o,
  output logic       in3_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] table_out_o,
  output logic [7:0] unstable_o
);

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StSampleA,
    StSampleB,
    StDone
  } state_e;

  // Last value of the hold counter before moving on to the first sample.
  localparam logic [7:0] SettleLast = 8'(Settle - 1);

  state_e     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sample_a_q, sample_a_d;
  logic [7:0] shadow_tt_q, shadow_tt_d;
  logic [7:0] shadow_us_q, shadow_us_d;
  logic [7:0] table_q, table_d;
  logic [7:0] unstable_q, unstable_d;

  // Shadow words with the current code's second sample merged in. Used both
  // to update the shadows and, on the last code, to load the visible result
  // so that code 7's sample lands in the same edge that enters StDone.
  logic [7:0] tt_merged;
  logic [7:0] us_merged;

  always_comb begin
    tt_merged          = shadow_tt_q;
    us_merged          = shadow_us_q;
    tt_merged[code_q]  = dut_out_i;
    us_merged[code_q]  = dut_out_i ^ sample_a_q;
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    sample_a_d  = sample_a_q;
    shadow_tt_d = shadow_tt_q;
    shadow_us_d = shadow_us_q;
    table_d     = table_q;
    unstable_d  = unstable_q;

    unique case (state_q)
      StIdle, StDone: begin
        // StDone always returns to idle, but a start seen there begins a new
        // sweep straight away.
        state_d = StIdle;
        if (start_i) begin
          state_d     = StHold;
          code_d      = 3'd0;
          cnt_d       = 8'd0;
          sample_a_d  = 1'b0;
          shadow_tt_d = 8'h00;
          shadow_us_d = 8'h00;
        end
      end

      StHold: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (cnt_q >= SettleLast) begin
          state_d = StSampleA;
          cnt_d   = 8'd0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StSampleA: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          sample_a_d = dut_out_i;
          state_d    = StSampleB;
        end
      end

      StSampleB: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          shadow_tt_d = tt_merged;
          shadow_us_d = us_merged;
          if (code_q == 3'd7) begin
            state_d    = StDone;
            table_d    = tt_merged;
            unstable_d = us_merged;
          end else begin
            code_d  = code_q + 3'd1;
            cnt_d   = 8'd0;
            state_d = StHold;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // An aborted sweep leaves nothing behind except the last completed result.
    if (state_d == StIdle) begin
      code_d      = 3'd0;
      cnt_d       = 8'd0;
      sample_a_d  = 1'b0;
      shadow_tt_d = 8'h00;
      shadow_us_d = 8'h00;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      code_q      <= 3'd0;
      cnt_q       <= 8'd0;
      sample_a_q  <= 1'b0;
      shadow_tt_q <= 8'h00;
      shadow_us_q <= 8'h00;
      table_q     <= 8'h00;
      unstable_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      sample_a_q  <= sample_a_d;
      shadow_tt_q <= shadow_tt_d;
      shadow_us_q <= shadow_us_d;
      table_q     <= table_d;
      unstable_q  <= unstable_d;
    end
  end

  // Output decode from registered state only.
  logic       running;
  logic [2:0] drive_code;

  always_comb begin
    running    = (state_q == StHold) || (state_q == StSampleA) || (state_q == StSampleB);
    drive_code = running ? code_q : 3'd0;
  end

  assign in1_o       = drive_code[2];
  assign in2_o       = drive_code[1];
  assign in3_o       = drive_code[0];
  assign busy_o      = running;
  assign done_o      = (state_q == StDone);
  assign table_out_o = table_q;
  assign unstable_o  = unstable_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
module tb_truth_table_sweep;

  localparam int Settle = 4;
  localparam int Per    = Settle + 2;  // cycles per code
  localparam int Len    = 8 * Per;     // busy cycles per sweep

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dut_out;
  logic       in1, in2, in3, busy, done;
  logic [7:0] table_out, unstable;

  truth_table_sweep #(.Settle(Settle)) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .abort_i    (abort),
    .dut_out_i  (dut_out),
    .in1_o      (in1),
    .in2_o      (in2),
    .in3_o      (in3),
    .busy_o     (busy),
    .done_o     (done),
    .table_out_o(table_out),
    .unstable_o (unstable)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench model of the logic module: truth-table byte, optional delay line,
  // optional one-cycle forced-high glitch.
  logic [7:0] fn = 8'h00;
  int         delay = 0;
  int         force_cyc = -1;
  logic [7:0] dline = 8'h00;
  logic [2:0] code_now;
  logic       f_now;

  assign code_now = {in1, in2, in3};
  assign f_now    = fn[code_now];

  always @(posedge clk) dline <= {dline[6:0], f_now};

  always_comb begin
    dut_out = (delay == 0) ? f_now : dline[3'(delay - 1)];
    if (cyc == force_cyc) dut_out = 1'b1;
  end

  // Scoreboard
  typedef struct {
    logic [7:0] tt;
    logic [7:0] us;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.at));
        check("table_out", 32'(table_out), 32'(e.tt));
        check("unstable", 32'(unstable), 32'(e.us));
      end
    end
  end

  // Pulse start for one cycle; returns the cycle in which it is sampled.
  // Leaves the caller at the negedge of cycle t0+1.
  task automatic pulse_start(input int force_off, output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    force_cyc = (force_off >= 0) ? cyc + force_off : -1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [7:0] tt, input logic [7:0] us, input int force_off,
                       output int t0);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    force_cyc = (force_off >= 0) ? cyc + force_off : -1;
    e.tt = tt;
    e.us = us;
    e.at = cyc + Len + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * Len && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in"}, 32'(code_now), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_table"}, 32'(table_out), 32'd0);
    check({tag, "_unstable"}, 32'(unstable), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;

    // Reset
    #3 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("post_reset");

    // Function 0x00 plus exact drive schedule
    fn = 8'h00;
    issue(8'h00, 8'h00, -1, t0);
    for (int n = 1; n <= Len; n++) begin
      check("sched_busy", 32'(busy), 32'd1);
      check("sched_code", 32'(code_now), 32'((n - 1) / Per));
      @(negedge clk);
    end
    check("end_busy", 32'(busy), 32'd0);
    check("end_code", 32'(code_now), 32'd0);
    drain();

    // Plain functions
    fn = 8'h80; issue(8'h80, 8'h00, -1, t0); drain();
    fn = 8'hAA; issue(8'hAA, 8'h00, -1, t0); drain();
    fn = 8'hF0; issue(8'hF0, 8'h00, -1, t0); drain();

    // in1^in2 (0x3C) through a delay line. Samples fall in cycles 6k+5 and
    // 6k+6 of a code. Delay 3: both see code k. Delay 6: both see code k-1,
    // so the table shifts up one code (0x78) with no instability. Delay 5:
    // first sample sees code k-1, second sees code k -> flags codes 2 and 6.
    fn = 8'h3C;
    delay = 3; issue(8'h3C, 8'h00, -1, t0); drain();
    delay = 6; issue(8'h78, 8'h00, -1, t0); drain();
    delay = 5; issue(8'h3C, 8'h44, -1, t0); drain();
    delay = 0;

    // Glitch during SAMPLE_A of code 3
    fn = 8'h00;
    issue(8'h00, 8'h08, 23, t0); drain();
    force_cyc = -1;

    // Abort mid-sweep, with an ignored start at cycle 10
    fn = 8'hAA;
    issue(8'hAA, 8'h00, -1, t0); drain();
    pulse_start(-1, t0);
    wait_until(t0 + 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_code", 32'(code_now), 32'd0);
    repeat (2 * Len) @(negedge clk);
    check("abort_table", 32'(table_out), 32'hAA);
    check("abort_unstable", 32'(unstable), 32'h00);
    issue(8'hAA, 8'h00, -1, t0); drain();

    // Asynchronous reset mid-sweep
    fn = 8'hF0;
    pulse_start(-1, t0);
    wait_until(t0 + 30);
    rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * Len) @(negedge clk);
    check("idle_table", 32'(table_out), 32'h00);
    issue(8'hF0, 8'h00, -1, t0); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
